// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store bus initiator: funct3 codes,
// FSM states, byte-enable generation and alignment checking.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: return 4'b0001 << addr_lo;
      F3_H, F3_HU: return 4'b0011 << {addr_lo[1], 1'b0};
      default:     return 4'b1111;
    endcase
  endfunction

  // Unknown funct3 codes are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return addr_lo[0];
      default:     return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: steers store data onto the enabled byte lanes and
// extracts/extends load data from the lane selected by the access address.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [3:0]  st_mask_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_rdata_o
);

  // Each lane picks its source byte by access size; the mask zeroes unused lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src_byte;
      always_comb begin
        case (st_funct3_i)
          F3_B, F3_BU: src_byte = st_wdata_i[7:0];
          F3_H, F3_HU: src_byte = st_wdata_i[8*(gi%2) +: 8];
          default:     src_byte = st_wdata_i[8*gi +: 8];
        endcase
      end
      assign st_wdata_o[8*gi +: 8] = st_mask_i[gi] ? src_byte : 8'h00;
    end
  endgenerate

  logic [31:0] shifted;
  assign shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_rdata_o = {24'h000000, shifted[7:0]};
      F3_H:    ld_rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_rdata_o = {16'h0000, shifted[15:0]};
      default: ld_rdata_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_initiator.sv
// Turns one CPU load/store into a single-cycle-select bus transaction, waits for
// the responder's registered valid and returns extended data or an error.
module lsu_bus_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_out,
  output logic        bus_rd_wr_en,
  output logic        bus_cs,
  output logic [3:0]  bus_mask,
  input  logic [31:0] bus_data_in,
  input  logic        bus_valid
);

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        misaligned;
  logic [3:0]  mask_new;
  logic [31:0] steered_wdata;
  logic [31:0] ld_ext;

  assign accept     = req_valid & (state_q == ST_IDLE);
  assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);
  assign mask_new   = size_mask(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .st_funct3_i  (req_funct3),
    .st_mask_i    (mask_new),
    .st_wdata_i   (req_wdata),
    .st_wdata_o   (steered_wdata),
    .ld_funct3_i  (funct3_q),
    .ld_addr_lo_i (addr_lo_q),
    .ld_rdata_i   (bus_data_in),
    .ld_rdata_o   (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready    = 1'b0;
    bus_cs       = 1'b0;
    bus_rd_wr_en = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)  state_d = ST_ERR;
          else if (req_we) state_d = ST_WR;
          else             state_d = ST_RD_REQ;
        end
      end
      ST_WR: begin
        bus_cs       = 1'b1;
        bus_rd_wr_en = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RD_REQ: begin
        bus_cs  = 1'b1;
        cnt_d   = 4'd0;
        state_d = ST_RD_WAIT;
      end
      // Valid wins over timeout if both land in the same cycle.
      ST_RD_WAIT: begin
        if (bus_valid) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT_C) state_d = ST_ERR;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'h0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      mask_q    <= 4'b0000;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Misaligned requests leave the bus registers untouched.
      if (accept && !misaligned) begin
        addr_q    <= {req_addr[31:2], 2'b00};
        addr_lo_q <= req_addr[1:0];
        funct3_q  <= req_funct3;
        mask_q    <= mask_new;
        wdata_q   <= req_we ? steered_wdata : 32'h0;
      end
      rdata_q <= (state_q == ST_RD_WAIT && bus_valid) ? ld_ext : 32'h0;
    end
  end

  assign bus_address  = addr_q;
  assign bus_data_out = wdata_q;
  assign bus_mask     = mask_q;
  assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Directed bench for lsu_bus_initiator with a small registered-valid memory
// responder; expected values are hand-computed constants.
module tb_lsu_bus_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_address;
  logic [31:0] bus_data_out;
  logic        bus_rd_wr_en;
  logic        bus_cs;
  logic [3:0]  bus_mask;
  logic [31:0] bus_data_in;
  logic        bus_valid;

  int n_checks = 0;
  int n_pass   = 0;

  lsu_bus_initiator #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus_address  (bus_address),
    .bus_data_out (bus_data_out),
    .bus_rd_wr_en (bus_rd_wr_en),
    .bus_cs       (bus_cs),
    .bus_mask     (bus_mask),
    .bus_data_in  (bus_data_in),
    .bus_valid    (bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: captures on the select cycle, raises valid two cycles later.
  logic [31:0] mem [16];
  logic        mem_ready = 1'b0;
  logic        resp_en;
  logic        stray_v;
  logic        resp_v;
  logic [31:0] rd_data_r;
  logic        pipe1, pipe2;
  logic [3:0]  pipe_addr;

  assign bus_valid   = resp_v | stray_v;
  assign bus_data_in = rd_data_r;

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[4]    = 32'h8899AABB;
      mem_ready = 1'b1;
    end
    if (rst) begin
      pipe1 = 1'b0; pipe2 = 1'b0; resp_v = 1'b0; rd_data_r = 32'h0; pipe_addr = 4'd0;
    end else begin
      resp_v = 1'b0;
      if (pipe2) begin
        resp_v    = 1'b1;
        rd_data_r = mem[pipe_addr];
      end
      pipe2 = pipe1;
      pipe1 = 1'b0;
      if (bus_cs && resp_en) begin
        if (bus_rd_wr_en) begin
          for (int b = 0; b < 4; b++)
            if (bus_mask[b]) mem[bus_address[5:2]][8*b +: 8] = bus_data_out[8*b +: 8];
        end else begin
          pipe1     = 1'b1;
          pipe_addr = bus_address[5:2];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Issues one request from a negedge and observes it until the response.
  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3,
                     input int exp_lat, input int exp_cs, input logic [3:0] exp_mask,
                     input logic [31:0] exp_dout, input logic [31:0] exp_rdata,
                     input logic exp_err);
    int          lat, cs_cnt;
    logic [3:0]  mask_seen;
    logic [31:0] dout_seen, addr_seen, rdata;
    logic        wr_seen, err, got, busy_bad;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    check({tag, "_ready_pre"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; cs_cnt = 0; got = 1'b0; busy_bad = 1'b0;
    mask_seen = 4'h0; dout_seen = 32'h0; addr_seen = 32'h0; wr_seen = 1'b0;
    rdata = 32'h0; err = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req_ready) busy_bad = 1'b1;
      if (bus_cs) begin
        cs_cnt++;
        mask_seen = bus_mask; dout_seen = bus_data_out;
        addr_seen = bus_address; wr_seen = bus_rd_wr_en;
      end
      if (rsp_valid) begin
        got = 1'b1; rdata = rsp_rdata; err = rsp_err;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    $display("txn %s we=%0d addr=0x%08h f3=%0d lat=%0d cs=%0d mask=%b dout=0x%08h rdata=0x%08h err=%0d",
             tag, we, addr, f3, lat, cs_cnt, mask_seen, dout_seen, rdata, err);
    check({tag, "_got_rsp"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_cs_cycles"}, 32'(cs_cnt), 32'(exp_cs));
    check({tag, "_busy_ready"}, {31'b0, busy_bad}, 32'd0);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    if (exp_cs != 0) begin
      check({tag, "_mask"}, {28'b0, mask_seen}, {28'b0, exp_mask});
      check({tag, "_dout"}, dout_seen, exp_dout);
      check({tag, "_wr_en"}, {31'b0, wr_seen}, {31'b0, we});
      check({tag, "_addr"}, addr_seen, {addr[31:2], 2'b00});
    end
    @(negedge clk);
    check({tag, "_rsp_single"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_ready_post"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_funct3 = 3'b000; resp_en = 1'b1; stray_v = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_ctrl", {24'b0, rsp_valid, rsp_err, bus_cs, bus_rd_wr_en, bus_mask}, 32'd0);
    check("rst_addr", bus_address, 32'h0);
    check("rst_dout", bus_data_out, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    //   tag       we    addr          wdata          f3      lat cs mask     dout           rdata          err
    run("lb_11",   1'b0, 32'h00000011, 32'h0,         3'b000, 4,  1, 4'b0010, 32'h0,         32'hFFFFFFAA, 1'b0);
    run("lhu_12",  1'b0, 32'h00000012, 32'h0,         3'b101, 4,  1, 4'b1100, 32'h0,         32'h00008899, 1'b0);
    run("sb_13",   1'b1, 32'h00000013, 32'h1234565A,  3'b000, 2,  1, 4'b1000, 32'h5A000000,  32'h0,        1'b0);
    run("lw_10",   1'b0, 32'h00000010, 32'h0,         3'b010, 4,  1, 4'b1111, 32'h0,         32'h5A99AABB, 1'b0);
    run("lw_06",   1'b0, 32'h00000006, 32'h0,         3'b010, 1,  0, 4'b0000, 32'h0,         32'h0,        1'b1);
    run("lb_12",   1'b0, 32'h00000012, 32'h0,         3'b000, 4,  1, 4'b0100, 32'h0,         32'hFFFFFF99, 1'b0);
    run("lh_10",   1'b0, 32'h00000010, 32'h0,         3'b001, 4,  1, 4'b0011, 32'h0,         32'hFFFFAABB, 1'b0);
    run("sh_12",   1'b1, 32'h00000012, 32'hCAFEBEEF,  3'b001, 2,  1, 4'b1100, 32'hBEEF0000,  32'h0,        1'b0);
    run("lbu_13",  1'b0, 32'h00000013, 32'h0,         3'b100, 4,  1, 4'b1000, 32'h0,         32'h000000BE, 1'b0);
    run("sh_11",   1'b1, 32'h00000011, 32'hFFFFFFFF,  3'b001, 1,  0, 4'b0000, 32'h0,         32'h0,        1'b1);
    run("lw_10b",  1'b0, 32'h00000010, 32'h0,         3'b010, 4,  1, 4'b1111, 32'h0,         32'hBEEFAABB, 1'b0);

    // Timeout, then a stray valid while idle must produce nothing.
    resp_en = 1'b0;
    run("lw_tmo",  1'b0, 32'h00000010, 32'h0,         3'b010, 17, 1, 4'b1111, 32'h0,         32'h0,        1'b1);
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || !req_ready) seen = 1'b1;
      @(negedge clk);
    end
    check("stray_valid_ignored", {31'b0, seen}, 32'd0);

    // Reset while waiting for read data.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00000010; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_ctrl", {24'b0, rsp_valid, rsp_err, bus_cs, bus_rd_wr_en, bus_mask}, 32'd0);
    check("mid_rst_addr", bus_address, 32'h0);
    check("mid_rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", {31'b0, seen}, 32'd0);
    run("lw_after_rst", 1'b0, 32'h00000010, 32'h0, 3'b010, 4, 1, 4'b1111, 32'h0, 32'hBEEFAABB, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
